// File: rtl/plc_io_pkg.sv
// plc_io_pkg: shared types and constants for the PLC analog I/O path
package plc_io_pkg;
  localparam int BITS_DEF = 16;
  localparam logic IO_DIR_IN = 1'b0;
  localparam logic IO_DIR_OUT = 1'b1;
  typedef enum logic [2:0] {IDLE, WAIT, SAMPLE, CAPTURE, OUTPUT} state_t;
endpackage

// File: rtl/analog_prescaler.sv
// analog_prescaler: free-running divide-by-DIV tick generator, parked at zero while disabled
module analog_prescaler #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt_q, cnt_d;
  if (DIV < 4) begin : g_div_chk
    $error("analog_prescaler: DIV must be at least 4");
  end
  assign tick = cnt_q == W'(DIV - 1);
  // wrap at DIV-1, hold at zero when the channel is off
  always_comb cnt_d = !en || tick ? '0 : cnt_q + W'(1);
  // count register
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/analog_in_filter.sv
// analog_in_filter: paced sampling, box-car averaging and hysteresis flag for one analog input
module analog_in_filter
  import plc_io_pkg::*;
#(
  parameter int BITS = BITS_DEF,
  parameter int AVG_LOG2 = 3,
  parameter int DIV = 1000,
  parameter int HYST = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [BITS-1:0] thr,
  input  logic [BITS-1:0] raw_in,
  output logic            io_en,
  output logic            io_dir,
  output logic [BITS-1:0] value,
  output logic            value_valid,
  output logic            above,
  output logic            busy
);
  localparam int AW = BITS + AVG_LOG2;
  localparam int CW = AVG_LOG2 == 0 ? 1 : AVG_LOG2;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);
  state_t state_q, state_d;
  logic [AW-1:0] acc_q, acc_d, acc_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BITS-1:0] value_q, value_d, avg, hi, lo;
  logic [BITS:0] hi_sum;
  logic above_q, above_d, tick;
  analog_prescaler #(.DIV(DIV)) u_pre (.clk(clk), .rst(rst), .en(en), .tick(tick));
  assign acc_nx = acc_q + AW'(raw_in);
  assign avg = BITS'(acc_nx >> AVG_LOG2);
  assign hi_sum = {1'b0, thr} + (BITS + 1)'(HYST);
  assign hi = hi_sum[BITS] ? '1 : hi_sum[BITS-1:0];
  assign lo = thr >= BITS'(HYST) ? thr - BITS'(HYST) : '0;
  assign io_en = state_q == SAMPLE;
  assign io_dir = IO_DIR_IN;
  assign value = value_q;
  assign value_valid = state_q == OUTPUT;
  assign above = above_q;
  assign busy = cnt_q != '0;
  // sequencing and accumulation; the final capture publishes value/above so they are visible in OUTPUT
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    value_d = value_q;
    above_d = above_q;
    if (!en) begin
      state_d = IDLE;
      acc_d = '0;
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT;
        WAIT: state_d = tick ? SAMPLE : WAIT;
        SAMPLE: state_d = CAPTURE;
        CAPTURE: begin
          acc_d = acc_nx;
          cnt_d = cnt_q + CW'(1);
          state_d = WAIT;
          if (cnt_q == CNT_LAST) begin
            state_d = OUTPUT;
            acc_d = '0;
            cnt_d = '0;
            value_d = avg;
            above_d = avg >= hi ? 1'b1 : avg < lo ? 1'b0 : above_q;
          end
        end
        OUTPUT: state_d = WAIT;
        default: state_d = IDLE;
      endcase
    end
  end
  // state registers
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      value_q <= '0;
      above_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      value_q <= value_d;
      above_q <= above_d;
    end
endmodule

// File: tb/tb_analog_in_filter.sv
// tb_analog_in_filter: randomized check of two filter instances (8-sample and 1-sample windows) against a timeline model
module tb_analog_in_filter;
  localparam int DIV = 4;
  localparam int HY = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic [15:0] thr = '0;
  logic [15:0] raw = '0;
  logic [15:0] val[2];
  logic io_e[2], dir[2], vv[2], ab[2], bs[2];
  int n_chk = 0;
  int n_pass = 0;
  int age = 0;
  int lg[2] = '{3, 0};
  int sum[2], cnt[2], ev[2], ea[2], evld[2];
  logic obs_io;
  analog_in_filter #(.BITS(16), .AVG_LOG2(3), .DIV(DIV), .HYST(HY)) dut0 (
    .clk(clk), .rst(rst), .en(en), .thr(thr), .raw_in(raw), .io_en(io_e[0]), .io_dir(dir[0]),
    .value(val[0]), .value_valid(vv[0]), .above(ab[0]), .busy(bs[0]));
  analog_in_filter #(.BITS(16), .AVG_LOG2(0), .DIV(DIV), .HYST(HY)) dut1 (
    .clk(clk), .rst(rst), .en(en), .thr(thr), .raw_in(raw), .io_en(io_e[1]), .io_dir(dir[1]),
    .value(val[1]), .value_valid(vv[1]), .above(ab[1]), .busy(bs[1]));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    logic ie;
    bit cap;
    int v, t, hi, lo;
    @(negedge clk);
    ie = age >= DIV && age % DIV == 0;
    obs_io = io_e[0];
    for (int i = 0; i < 2; i++) begin
      check($sformatf("io_en%0d", i), io_e[i], ie);
      check($sformatf("io_dir%0d", i), dir[i], 0);
      check($sformatf("valid%0d", i), vv[i], evld[i]);
      check($sformatf("value%0d", i), val[i], ev[i]);
      check($sformatf("above%0d", i), ab[i], ea[i]);
      check($sformatf("busy%0d", i), bs[i], cnt[i] != 0);
    end
    cap = age > DIV && (age - 1) % DIV == 0;
    t = thr;
    hi = t + HY > 65535 ? 65535 : t + HY;
    lo = t < HY ? 0 : t - HY;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        sum[i] = 0; cnt[i] = 0; ev[i] = 0; ea[i] = 0; evld[i] = 0;
      end else if (!en) begin
        sum[i] = 0; cnt[i] = 0; evld[i] = 0;
      end else begin
        evld[i] = 0;
        if (cap) begin
          sum[i] += raw;
          cnt[i]++;
          if (cnt[i] == (1 << lg[i])) begin
            v = sum[i] >> lg[i];
            ev[i] = v;
            ea[i] = v >= hi ? 1 : v < lo ? 0 : ea[i];
            sum[i] = 0; cnt[i] = 0; evld[i] = 1;
          end
        end
      end
    end
    age = rst || !en ? 0 : age + 1;
    @(posedge clk);
    #1;
  endtask
  task automatic restart();
    en = 1'b0;
    step();
    en = 1'b1;
  endtask
  task automatic wait_window(input int mode);
    for (int k = 0; k < 200; k++) begin
      if (mode == 1) raw = ((age / DIV) % 2) != 0 ? 16'hFFFF : 16'h0000;
      if (mode == 2) raw = 16'($urandom);
      step();
      if (evld[0] != 0) return;
    end
    check("window_timeout", 0, 1);
  endtask
  initial begin
    int first;
    rst = 1'b1; en = 1'b1;
    step(); step();
    rst = 1'b0;
    first = -1;
    for (int k = 0; k < 16; k++) begin
      step();
      if (obs_io && first < 0) first = k;
    end
    check("t1_first_io_en", first, 4);
    restart(); raw = 16'h1234; wait_window(0);
    check("t2_value", val[0], 16'h1234);
    check("t6_value", val[1], 16'h1234);
    restart(); wait_window(1);
    check("t3_alt", val[0], 16'h7FFF);
    restart(); raw = 16'hFFFF; wait_window(0);
    check("t3_max", val[0], 16'hFFFF);
    thr = 16'h1000;
    restart(); raw = 16'h1010; wait_window(0);
    check("t4_above_1010", ab[0], 1);
    restart(); raw = 16'h0FF5; wait_window(0);
    check("t4_above_0ff5", ab[0], 1);
    restart(); raw = 16'h0FEF; wait_window(0);
    check("t4_above_0fef", ab[0], 0);
    thr = 16'hFFF8;
    restart(); raw = 16'hFFFF; wait_window(0);
    check("t4_above_sat", ab[0], 1);
    restart(); raw = 16'h5555;
    for (int k = 0; k < 100 && cnt[0] < 5; k++) step();
    check("t5_partial", bs[0], 1);
    en = 1'b0;
    repeat (3) step();
    en = 1'b1; raw = 16'h0ABC;
    wait_window(0);
    check("t5_value", val[0], 16'h0ABC);
    restart(); raw = 16'h4321;
    repeat (20) step();
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_value", val[0], 0);
    thr = 16'h8000;
    for (int k = 0; k < 2000; k++) begin
      raw = 16'h7FC0 + 16'($urandom_range(0, 128));
      en = $urandom_range(0, 199) != 0;
      rst = $urandom_range(0, 999) == 0;
      step();
    end
    rst = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      raw = 16'($urandom);
      if ($urandom_range(0, 49) == 0) thr = 16'($urandom);
      en = $urandom_range(0, 149) != 0;
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
